// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-control types for the five-stage core:
// operand forward selects and hazard sequencer FSM states.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hc_state_e;

endpackage

// File: rtl/forward_unit.sv
// Single-operand Execute forward select.
// Memory-stage result wins over Writeback.
module forward_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs_e)
      fwd = FWD_M;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs_e)
      fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/forward sequencer with memory-wait FSM.
// Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             LoadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  hc_state_e  state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       pend_q, pend_d;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_stall, tmo, load_use, ctrl;

  forward_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  always_comb begin
    tmo = (state_q == TIMEOUT);
    mem_stall = ((state_q == RUN) && MemReqM && !MemReadyM)
             || ((state_q == MEM_WAIT) && !MemReadyM);
    load_use = LoadE && (RdE != 5'd0)
            && ((RdE == Rs1D) || (RdE == Rs2D));
    // a branch seen while Execute was frozen stays pending
    ctrl = PCSrcE || pend_q;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d = TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (mem_stall && PCSrcE)
      pend_d = 1'b1;
    else if (!mem_stall && !tmo)
      pend_d = 1'b0;
  end

  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    ForwardAE  = FWD_RF;
    ForwardBE  = FWD_RF;
    MemTimeout = 1'b0;
    if (Rst) begin
      ForwardAE  = fwd_a;
      ForwardBE  = fwd_b;
      MemTimeout = tmo;
      if (mem_stall || tmo) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (ctrl) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(StallF);
    flush_cnt_d = flush_cnt_q + CNT_W'(FlushE);
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed cases then
// randomized traffic against a behavioural pipeline model.
module tb_hazard_controller;

  localparam int MW = 4;
  localparam int CW = 8;

  logic CLK = 1'b0;
  logic Rst = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
  logic [4:0] RdE = '0, RdM = '0, RdW = '0;
  logic LoadE = 0, RegWriteM = 0, RegWriteW = 0;
  logic PCSrcE = 0, MemReqM = 0, MemReadyM = 0;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic MemTimeout;
  logic [CW-1:0] StallCnt, FlushCnt;

  hazard_controller #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .CLK(CLK), .Rst(Rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .LoadE(LoadE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeout(MemTimeout),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       loade, rwm, rww, pcsrc, req, rdy;
  } in_t;

  typedef struct packed {
    logic [3:0]    stall;
    logic [2:0]    flush;
    logic [1:0]    fa, fb;
    logic          tmo;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int waited = 0;
  bit timed_out = 0;
  bit pend = 0;
  int sc_m = 0;
  int fc_m = 0;

  function automatic logic [1:0] fwd_ref(
    input logic [4:0] rs, input logic rwm, input logic [4:0] rdm,
    input logic rww, input logic [4:0] rdw);
    if (rwm && rdm != 0 && rdm == rs) return 2'b10;
    if (rww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  task automatic drive(input in_t v);
    exp_t e;
    bit ms, lu, br;
    @(negedge CLK);
    Rst = v.rst_n; Rs1D = v.rs1d; Rs2D = v.rs2d;
    Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
    RdM = v.rdm; RdW = v.rdw; LoadE = v.loade;
    RegWriteM = v.rwm; RegWriteW = v.rww;
    PCSrcE = v.pcsrc; MemReqM = v.req; MemReadyM = v.rdy;
    e = '0;
    if (!v.rst_n) begin
      waited = 0; timed_out = 0; pend = 0;
      sc_m = 0; fc_m = 0;
    end else begin
      ms = !timed_out && !v.rdy && (waited > 0 || v.req);
      lu = v.loade && v.rde != 0
        && (v.rde == v.rs1d || v.rde == v.rs2d);
      br = v.pcsrc || pend;
      e.fa = fwd_ref(v.rs1e, v.rwm, v.rdm, v.rww, v.rdw);
      e.fb = fwd_ref(v.rs2e, v.rwm, v.rdm, v.rww, v.rdw);
      if (ms || timed_out) begin
        e.stall = 4'b1111; e.flush = 3'b001;
      end else if (br) begin
        e.flush = 3'b110;
      end else if (lu) begin
        e.stall = 4'b1100; e.flush = 3'b010;
      end
      e.tmo = timed_out;
`ifdef HAZARD_PERF_CNT_EN
      e.sc = CW'(sc_m);
      e.fc = CW'(fc_m);
`endif
      if (e.stall[3]) sc_m++;
      if (e.flush[1]) fc_m++;
      if (ms && v.pcsrc) pend = 1;
      else if (!ms && !timed_out) pend = 0;
      if (!timed_out) begin
        if (waited == 0) begin
          if (v.req && !v.rdy) waited = 1;
        end else if (v.rdy) waited = 0;
        else if (waited == MW) timed_out = 1;
        else waited++;
      end
    end
    sb.push_back(e);
  endtask

  function automatic void chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h",
               nm, cyc, act, exp);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", 32'({StallF, StallD, StallE, StallM}),
            32'(e.stall));
        chk("flush", 32'({FlushD, FlushE, FlushW}), 32'(e.flush));
        chk("fwdA", 32'(ForwardAE), 32'(e.fa));
        chk("fwdB", 32'(ForwardBE), 32'(e.fb));
        chk("timeout", 32'(MemTimeout), 32'(e.tmo));
        chk("stallcnt", 32'(StallCnt), 32'(e.sc));
        chk("flushcnt", 32'(FlushCnt), 32'(e.fc));
        cyc++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    in_t v;
    v = idle(); v.rst_n = 0; v.rs1e = 3; v.rwm = 1; v.rdm = 3;
    drive(v); drive(v);
    v = idle(); drive(v);
    v = idle(); v.rwm = 1; v.rdm = 5; v.rww = 1; v.rdw = 5;
    v.rs1e = 5; drive(v);
    v.rdm = 0; drive(v);
    v = idle(); v.loade = 1; v.rde = 7; v.rs2d = 7; drive(v);
    v = idle(); v.rwm = 1; v.rdm = 7; v.rs2e = 7; drive(v);
    v = idle(); v.loade = 1; v.rde = 7; v.rs1d = 7;
    v.pcsrc = 1; drive(v);
    v = idle(); v.req = 1; repeat (3) drive(v);
    v.rdy = 1; drive(v);
    v = idle(); drive(v);
    v = idle(); v.req = 1; drive(v);
    v.pcsrc = 1; drive(v); drive(v);
    v.rdy = 1; drive(v);
    v = idle(); drive(v);
    v = idle(); v.req = 1; v.pcsrc = 1; drive(v);
    v.pcsrc = 0; drive(v);
    v.rdy = 1; drive(v);
    v = idle(); drive(v);
    v = idle(); v.req = 1; repeat (8) drive(v);
    v = idle(); v.rdy = 1; v.pcsrc = 1; repeat (2) drive(v);
    v = idle(); v.rst_n = 0; drive(v);
    v = idle(); v.req = 1; repeat (2) drive(v);
    v.rst_n = 0; drive(v);
    v = idle(); drive(v);
    v.req = 1; v.rdy = 1; drive(v);
    for (int i = 0; i < 3000; i++) begin
      v.rst_n = !((i % 150) == 149);
      v.rs1d = 5'($urandom_range(0, 3));
      v.rs2d = 5'($urandom_range(0, 3));
      v.rs1e = 5'($urandom_range(0, 3));
      v.rs2e = 5'($urandom_range(0, 3));
      v.rde = 5'($urandom_range(0, 3));
      v.rdm = 5'($urandom_range(0, 3));
      v.rdw = ($urandom_range(0, 9) == 0) ?
              5'($urandom) : 5'($urandom_range(0, 3));
      v.loade = ($urandom_range(0, 9) < 3);
      v.rwm = ($urandom_range(0, 1) == 1);
      v.rww = ($urandom_range(0, 1) == 1);
      v.pcsrc = ($urandom_range(0, 19) < 3);
      v.req = ($urandom_range(0, 9) < 3);
      v.rdy = ($urandom_range(0, 19) < 11);
      drive(v);
    end
    repeat (2) @(negedge CLK);
    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
